// File: rtl/sfx_output_mixer.sv
// Sound-effect output mixer: tracks which 1-bit tone sources are sounding,
// picks the highest-priority one, applies its PWM volume gate and the global
// mute, and drives the single speaker pin through an output register.
module sfx_output_mixer #(
    parameter int NUM_SRC     = 4,
    parameter int ACT_TIMEOUT = 65536,
    parameter int VOL_BITS    = 4,
    localparam int SEL_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_SRC-1:0]           src_in,
    input  logic [NUM_SRC*VOL_BITS-1:0]  src_vol,
    input  logic                         mute,
    output logic                         audio_out,
    output logic                         any_active,
    output logic [SEL_W-1:0]             sel_src
);

    localparam int                CNT_W   = $clog2(ACT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TIMEOUT = CNT_W'(ACT_TIMEOUT);

    // Saturating activity counter: cleared by a toggle, counts up to TIMEOUT
    // and then holds so a long-silent source never wraps back to active.
    function automatic logic [CNT_W-1:0] act_cnt_next(
        input logic [CNT_W-1:0] cnt,
        input logic             toggled
    );
        if (toggled) begin
            return '0;
        end else if (cnt < TIMEOUT) begin
            return cnt + CNT_W'(1);
        end else begin
            return cnt;
        end
    endfunction

    logic [NUM_SRC-1:0]  src_q;
    logic [NUM_SRC-1:0]  prev_q;
    logic [CNT_W-1:0]    cnt_q [NUM_SRC];
    logic [CNT_W-1:0]    cnt_d [NUM_SRC];
    logic [NUM_SRC-1:0]  active;
    logic [VOL_BITS-1:0] pwm_q;
    logic [VOL_BITS-1:0] pwm_d;

    logic                any_act;
    logic [SEL_W-1:0]    sel;
    logic [VOL_BITS-1:0] vol_sel;
    logic                src_sel;
    logic                gate;

    logic                audio_q;
    logic                audio_d;
    logic                any_q;
    logic                any_d;
    logic [SEL_W-1:0]    sel_q;
    logic [SEL_W-1:0]    sel_d;

    // Per-source activity tracking from the registered input and its delayed copy.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            cnt_d[i]  = act_cnt_next(cnt_q[i], src_q[i] ^ prev_q[i]);
            active[i] = (cnt_q[i] < TIMEOUT);
        end
    end

    // Fixed-priority pick: scanning high index to low lets the lowest active index win.
    always_comb begin
        sel     = '0;
        vol_sel = '0;
        src_sel = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                sel     = SEL_W'(i);
                vol_sel = src_vol[i*VOL_BITS +: VOL_BITS];
                src_sel = src_q[i];
            end
        end
    end

    // Volume gate and next output values; all-ones volume bypasses the PWM entirely.
    always_comb begin
        any_act = |active;
        pwm_d   = pwm_q + VOL_BITS'(1);
        gate    = (vol_sel == '1) | (pwm_q < vol_sel);
        audio_d = any_act & ~mute & src_sel & gate;
        any_d   = any_act;
        sel_d   = any_act ? sel : '0;
    end

    // Stage 1 input/activity state and stage 2 output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q   <= '0;
            prev_q  <= '0;
            pwm_q   <= '0;
            audio_q <= 1'b0;
            any_q   <= 1'b0;
            sel_q   <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i] <= TIMEOUT;
            end
        end else begin
            src_q   <= src_in;
            prev_q  <= src_q;
            pwm_q   <= pwm_d;
            audio_q <= audio_d;
            any_q   <= any_d;
            sel_q   <= sel_d;
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign audio_out  = audio_q;
    assign any_active = any_q;
    assign sel_src    = sel_q;

endmodule
